// File: rtl/cache_pkg.sv
// Shared widths, address field positions and FSM state encoding for the
// direct-mapped cache controller.
package cache_pkg;

  localparam int TAG_W   = 10;
  localparam int IDX_W   = 6;
  localparam int DATA_W  = 32;
  localparam int LINES   = 2 ** IDX_W;
  localparam int OFF_W   = 2;
  localparam int ADDR_W  = TAG_W + IDX_W + OFF_W;

  // Byte address layout is {tag, index, byte_offset}
  localparam int IDX_LSB = OFF_W;
  localparam int TAG_LSB = OFF_W + IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    COMPARE,
    MEM_RD,
    FILL,
    MEM_WR,
    RESPOND
  } state_t;

endpackage

// File: rtl/cache_data.sv
// 64x32 cache data array: synchronous write, asynchronous read, one shared
// index for both. Contents are deliberately left uninitialised on reset.
module cache_data
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [LINES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller driving an
// external tag store. Define CACHE_STATS_EN to add load hit/miss counters.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              flush,
  output logic [IDX_W-1:0]  tag_index,
  output logic [TAG_W-1:0]  tag_addr_in,
  output logic              tag_fetch,
  output logic              tag_update,
  input  logic [TAG_W-1:0]  tag_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  state_t            state;
  state_t            next_state;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;

  logic [LINES-1:0]  valid;
  logic              hit;
  logic              accept;
  logic              flush_now;

  logic              data_we;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] line_data;

  // Only whole words are stored, so the byte offset is intentionally dropped.
  logic              unused_offset;
  assign unused_offset = ^cpu_addr[OFF_W-1:0];

  assign flush_now = (state == IDLE) && flush;
  assign accept    = (state == IDLE) && !flush && cpu_req;
  assign hit       = valid[req_idx] && (tag_rd == req_tag);

  assign tag_index   = req_idx;
  assign tag_addr_in = req_tag;

  cache_data u_data (
    .clk   (clk),
    .we    (data_we),
    .addr  (req_idx),
    .wdata (data_wdata),
    .rdata (line_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The request is captured once and held for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_tag   <= '0;
      req_idx   <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
    end else if (accept) begin
      req_tag   <= cpu_addr[TAG_LSB +: TAG_W];
      req_idx   <= cpu_addr[IDX_LSB +: IDX_W];
      req_we    <= cpu_we;
      req_wdata <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (flush_now) begin
      valid <= '0;
    end else if (state == FILL) begin
      valid[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata <= '0;
    end else if ((state == COMPARE) && !req_we && hit) begin
      cpu_rdata <= line_data;
    end else if ((state == MEM_RD) && mem_ack) begin
      cpu_rdata <= mem_rdata;
    end
  end

  always_comb begin
    next_state = state;
    tag_fetch  = 1'b0;
    tag_update = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_ready  = 1'b0;
    data_we    = 1'b0;
    data_wdata = '0;

    unique case (state)
      IDLE: begin
        if (!flush && cpu_req) begin
          next_state = LOOKUP;
        end
      end
      LOOKUP: begin
        tag_fetch  = 1'b1;
        next_state = COMPARE;
      end
      COMPARE: begin
        if (req_we) begin
          data_we    = hit;
          data_wdata = req_wdata;
          next_state = MEM_WR;
        end else if (hit) begin
          next_state = RESPOND;
        end else begin
          next_state = MEM_RD;
        end
      end
      MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (mem_ack) begin
          data_we    = 1'b1;
          data_wdata = mem_rdata;
          next_state = FILL;
        end
      end
      FILL: begin
        tag_update = 1'b1;
        next_state = RESPOND;
      end
      MEM_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
        mem_wdata = req_wdata;
        if (mem_ack) begin
          next_state = RESPOND;
        end
      end
      RESPOND: begin
        cpu_ready  = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

`ifdef CACHE_STATS_EN
  // Load-only statistics, sampled in the single COMPARE cycle of each load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (flush_now) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if ((state == COMPARE) && !req_we) begin
      if (hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end else begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl with a negedge tag-store model
// and a memory responder that acks after a programmable number of cycles.
module tb_cache_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [17:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        flush;
  logic [5:0]  tag_index;
  logic [9:0]  tag_addr_in;
  logic        tag_fetch;
  logic        tag_update;
  logic [9:0]  tag_rd = '0;
  logic        mem_req;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  logic        resp_ack = 1'b0;
  logic        manual_ack;
  logic        resp_enable;
  int          mem_delay;
  logic [31:0] resp_data;
  int          resp_cnt = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  logic [17:0] last_addr = '0;
  logic        last_we = 1'b0;
  logic [31:0] last_wdata = '0;

  logic [9:0]  tag_mem [64];
  int          upd_count = 0;
  int          fetch_count = 0;
  int          both_high = 0;
  logic [9:0]  last_upd_tag = '0;
  logic [5:0]  last_upd_idx = '0;

  int          vectors = 0;
  int          miscompares = 0;

  assign mem_ack   = resp_ack | manual_ack;
  assign mem_rdata = resp_data;

  cache_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ready   (cpu_ready),
    .flush       (flush),
    .tag_index   (tag_index),
    .tag_addr_in (tag_addr_in),
    .tag_fetch   (tag_fetch),
    .tag_update  (tag_update),
    .tag_rd      (tag_rd),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External tag store: samples its strobes on the falling edge.
  always @(negedge clk) begin
    if (tag_update) begin
      tag_mem[tag_index] <= tag_addr_in;
      upd_count          <= upd_count + 1;
      last_upd_tag       <= tag_addr_in;
      last_upd_idx       <= tag_index;
    end
    if (tag_fetch) begin
      tag_rd      <= tag_mem[tag_index];
      fetch_count <= fetch_count + 1;
    end
    if (tag_fetch && tag_update) begin
      both_high <= both_high + 1;
    end
  end

  // Memory responder: ack in the mem_delay-th cycle that mem_req is seen high.
  always @(negedge clk) begin
    if (resp_ack) begin
      resp_ack <= 1'b0;
      resp_cnt <= 0;
    end else if (resp_enable && mem_req) begin
      resp_cnt <= resp_cnt + 1;
      if (resp_cnt + 1 == mem_delay) begin
        resp_ack   <= 1'b1;
        last_addr  <= mem_addr;
        last_we    <= mem_we;
        last_wdata <= mem_wdata;
        if (mem_we) wr_count <= wr_count + 1;
        else        rd_count <= rd_count + 1;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one request and returns the cycle (counted from the sampling edge)
  // in which cpu_ready was seen, or -1 if it never came.
  task automatic apply_stimulus(input logic we, input logic [17:0] addr,
                                input logic [31:0] wdata, input logic with_flush,
                                output int latency, output logic [31:0] rdata);
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    flush     = with_flush;
    latency   = -1;
    rdata     = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      flush = 1'b0;
      if (cpu_ready) begin
        latency = k;
        rdata   = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  int          lat;
  logic [31:0] rd;
  int          rd0;
  int          wr0;
  int          upd0;
  int          fet0;
  int          activity;

  // Tag is addr[17:8], index is addr[7:2]: 0x00104 -> tag 0x001 idx 1,
  // 0x10104 -> tag 0x101 idx 1, 0x3FFFC -> tag 0x3FF idx 63.
  initial begin
    rst         = 1'b1;
    cpu_req     = 1'b0;
    cpu_we      = 1'b0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    flush       = 1'b0;
    manual_ack  = 1'b0;
    resp_enable = 1'b1;
    mem_delay   = 1;
    resp_data   = '0;

    repeat (2) @(negedge clk);
    check_output("reset_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check_output("reset_cpu_rdata", cpu_rdata, 32'd0);
    check_output("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check_output("reset_tag_strobes", {30'd0, tag_fetch, tag_update}, 32'd0);
    check_output("reset_mem_addr", {14'd0, mem_addr}, 32'd0);
    check_output("reset_tag_index", {26'd0, tag_index}, 32'd0);
    rst = 1'b0;

    // Cold load miss with a two-cycle memory response.
    rd0 = rd_count; upd0 = upd_count;
    mem_delay = 2; resp_data = 32'hDEADBEEF;
    apply_stimulus(1'b0, 18'h00104, '0, 1'b0, lat, rd);
    check_output("miss1_latency", 32'(lat), 32'd6);
    check_output("miss1_rdata", rd, 32'hDEADBEEF);
    check_output("miss1_mem_reads", 32'(rd_count - rd0), 32'd1);
    check_output("miss1_mem_addr", {14'd0, last_addr}, 32'h00104);
    check_output("miss1_mem_we", {31'd0, last_we}, 32'd0);
    check_output("miss1_fill_tag", {22'd0, last_upd_tag}, 32'h001);
    check_output("miss1_fill_idx", {26'd0, last_upd_idx}, 32'd1);
    check_output("miss1_fill_count", 32'(upd_count - upd0), 32'd1);

    // Same address again hits.
    rd0 = rd_count; upd0 = upd_count; fet0 = fetch_count;
    apply_stimulus(1'b0, 18'h00104, '0, 1'b0, lat, rd);
    check_output("hit1_latency", 32'(lat), 32'd3);
    check_output("hit1_rdata", rd, 32'hDEADBEEF);
    check_output("hit1_mem_reads", 32'(rd_count - rd0), 32'd0);
    check_output("hit1_fetches", 32'(fetch_count - fet0), 32'd1);
    check_output("hit1_fills", 32'(upd_count - upd0), 32'd0);

    // Conflicting tag on index 1 with a zero-wait ack.
    rd0 = rd_count;
    mem_delay = 1; resp_data = 32'hCAFEF00D;
    apply_stimulus(1'b0, 18'h10104, '0, 1'b0, lat, rd);
    check_output("conflict_latency", 32'(lat), 32'd5);
    check_output("conflict_rdata", rd, 32'hCAFEF00D);
    check_output("conflict_mem_reads", 32'(rd_count - rd0), 32'd1);
    check_output("conflict_fill_tag", {22'd0, last_upd_tag}, 32'h101);

    // Store hit: write-through and the line is updated.
    rd0 = rd_count; wr0 = wr_count;
    mem_delay = 2;
    apply_stimulus(1'b1, 18'h10104, 32'h12345678, 1'b0, lat, rd);
    check_output("store_hit_latency", 32'(lat), 32'd5);
    check_output("store_hit_writes", 32'(wr_count - wr0), 32'd1);
    check_output("store_hit_mem_we", {31'd0, last_we}, 32'd1);
    check_output("store_hit_mem_addr", {14'd0, last_addr}, 32'h10104);
    check_output("store_hit_mem_wdata", last_wdata, 32'h12345678);

    rd0 = rd_count;
    apply_stimulus(1'b0, 18'h10104, '0, 1'b0, lat, rd);
    check_output("load_after_store_latency", 32'(lat), 32'd3);
    check_output("load_after_store_rdata", rd, 32'h12345678);
    check_output("load_after_store_reads", 32'(rd_count - rd0), 32'd0);

    // The earlier tag on index 1 was evicted.
    rd0 = rd_count;
    mem_delay = 1; resp_data = 32'hDEADBEEF;
    apply_stimulus(1'b0, 18'h00104, '0, 1'b0, lat, rd);
    check_output("evicted_latency", 32'(lat), 32'd5);
    check_output("evicted_mem_reads", 32'(rd_count - rd0), 32'd1);

    // Store miss does not allocate.
    wr0 = wr_count;
    apply_stimulus(1'b1, 18'h3FFFC, 32'hA5A5A5A5, 1'b0, lat, rd);
    check_output("store_miss_latency", 32'(lat), 32'd4);
    check_output("store_miss_mem_addr", {14'd0, last_addr}, 32'h3FFFC);
    check_output("store_miss_writes", 32'(wr_count - wr0), 32'd1);

    rd0 = rd_count;
    resp_data = 32'h0BADF00D;
    apply_stimulus(1'b0, 18'h3FFFC, '0, 1'b0, lat, rd);
    check_output("no_alloc_reads", 32'(rd_count - rd0), 32'd1);
    check_output("no_alloc_rdata", rd, 32'h0BADF00D);

    // Byte offset is ignored: 0x3FFFF hits the same word.
    rd0 = rd_count;
    apply_stimulus(1'b0, 18'h3FFFF, '0, 1'b0, lat, rd);
    check_output("offset_hit_latency", 32'(lat), 32'd3);
    check_output("offset_hit_rdata", rd, 32'h0BADF00D);

    // Flush in IDLE invalidates everything.
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    rd0 = rd_count;
    resp_data = 32'hDEADBEEF;
    apply_stimulus(1'b0, 18'h00104, '0, 1'b0, lat, rd);
    check_output("post_flush_reads", 32'(rd_count - rd0), 32'd1);
    check_output("post_flush_latency", 32'(lat), 32'd5);

    // Flush and request together: flush wins, request is taken one cycle later.
    rd0 = rd_count;
    apply_stimulus(1'b0, 18'h00104, '0, 1'b1, lat, rd);
    check_output("flush_req_latency", 32'(lat), 32'd6);
    check_output("flush_req_reads", 32'(rd_count - rd0), 32'd1);
    check_output("flush_req_rdata", rd, 32'hDEADBEEF);

    // Reset during MEM_RD before any ack.
    resp_enable = 1'b0;
    upd0 = upd_count;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h20008;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_req) begin
        lat = k;
        break;
      end
    end
    check_output("rst_mid_reached_mem_rd", 32'(lat), 32'd3);
    #2 rst = 1'b1;
    #1;
    check_output("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    check_output("rst_mid_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check_output("rst_mid_cpu_rdata", cpu_rdata, 32'd0);
    cpu_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); manual_ack = 1'b1;
    @(negedge clk); manual_ack = 1'b0;
    activity = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cpu_ready || mem_req || tag_fetch || tag_update) activity++;
    end
    check_output("late_ack_ignored", 32'(activity), 32'd0);
    check_output("late_ack_no_fill", 32'(upd_count - upd0), 32'd0);

    resp_enable = 1'b1;
    rd0 = rd_count;
    apply_stimulus(1'b0, 18'h00104, '0, 1'b0, lat, rd);
    check_output("post_rst_miss_reads", 32'(rd_count - rd0), 32'd1);
    check_output("post_rst_miss_latency", 32'(lat), 32'd5);
    rd0 = rd_count;
    resp_data = 32'h0BADF00D;
    apply_stimulus(1'b0, 18'h3FFFC, '0, 1'b0, lat, rd);
    check_output("post_rst_miss2_reads", 32'(rd_count - rd0), 32'd1);

    check_output("strobes_exclusive", 32'(both_high), 32'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
